branch_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage MIPS core.
- Consumes the MEM-stage branch decision (branch AND zero) and the load-use hazard conditions.
- Drives PC/IF-ID write enables, the PC source select, the ID/EX bubble and the stage flushes.
- Policy: predict-not-taken, branch resolved in MEM, single-cycle load-use stall.
- Replaces the standalone branch gate plus ad-hoc stall wiring in the top level.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/branch_hazard_ctrl_sat_counter.sv | 25 ++
 rtl/branch_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state
// encodings and default widths. Included by every pipeline control file.
package pipeline_ctrl_pkg;

  localparam int DEFAULT_REG_W = 5;
  localparam int DEFAULT_CNT_W = 16;

  // RUN is the resting state; STALL and FLUSH each last exactly one cycle.
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline statistics. Holds at the
// all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count up on inc, stopping at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Predict-not-taken with branches resolved in MEM, plus a single-cycle
// load-use stall. A taken branch squashes IF/ID, ID/EX and EX/MEM.
// Optional statistics counters are built only when the macro
// BRANCH_HAZARD_STATS_EN is defined; otherwise the count outputs are 0.
module branch_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = DEFAULT_REG_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_zero,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             pc_src,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t r_state;
  state_t w_nextState;
  logic   w_taken;
  logic   w_hazard;

  assign w_taken  = ex_mem_branch & ex_mem_zero;
  assign w_hazard = id_ex_memread & (id_ex_rt != '0) &
                    ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

  // State register; reset drops straight back to RUN so nothing pending survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and control outputs; taken branch outranks load-use hazard,
  // FLUSH ignores everything from squashed slots, illegal codes fall to RUN.
  always_comb begin
    w_nextState  = RUN;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    pc_src       = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    case (r_state)
      RUN, STALL: begin
        if (w_taken) begin
          pc_src       = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          w_nextState  = FLUSH;
        end else if ((r_state == RUN) && w_hazard) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          w_nextState  = STALL;
        end
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
    if (reset) begin
      w_nextState  = RUN;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b0;
      pc_src       = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
    end
  end

`ifdef BRANCH_HAZARD_STATS_EN
  logic w_branchInc;
  logic w_takenInc;
  logic w_stallInc;

  assign w_branchInc = ex_mem_branch & (r_state != FLUSH);
  assign w_takenInc  = w_taken & (r_state != FLUSH);
  assign w_stallInc  = (r_state == RUN) & w_hazard & ~w_taken;

  sat_counter #(.CNT_W(CNT_W)) u_branchCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_branchInc),
    .count (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_takenCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_takenInc),
    .count (taken_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stallInc),
    .count (stall_cnt)
  );
`else
  assign branch_cnt = '0;
  assign taken_cnt  = '0;
  assign stall_cnt  = '0;
`endif

endmodule
